// File: rtl/multi_debounce_pkg.sv
// rtl/multi_debounce_pkg.sv - shared state encoding and count-width helper for the switch debouncer
package multi_debounce_pkg;

  // Per-channel debounce states; bit 1 doubles as the debounced level.
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_t;

  // Counter width able to hold 0..STABLE_TICKS; never narrower than one bit.
  function automatic int cnt_width(input int stable_ticks);
    return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounce FSM with its tick counter and registered rise/fall pulses
module debounce_channel
  import multi_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_bit,
  input  logic tick,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int            CW   = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  db_state_t     r_state;
  db_state_t     w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_rise;
  logic          r_fall;
  logic          w_rise_next;
  logic          w_fall_next;

  // State, count and edge-pulse registers; reset drops everything to an idle ZERO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ZERO;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
    end
  end

  // Next state: a level change opens a window, a bounce closes it even on a tick cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ZERO: begin
        if (sw_bit) begin
          w_state_next = WAIT1;
          w_cnt_next   = '0;
        end
      end
      WAIT1: begin
        if (!sw_bit) begin
          w_state_next = ZERO;
          w_cnt_next   = '0;
        end else if (tick) begin
          if (r_cnt == LAST) begin
            w_state_next = ONE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      ONE: begin
        if (!sw_bit) begin
          w_state_next = WAIT0;
          w_cnt_next   = '0;
        end
      end
      WAIT0: begin
        if (sw_bit) begin
          w_state_next = ONE;
          w_cnt_next   = '0;
        end else if (tick) begin
          if (r_cnt == LAST) begin
            w_state_next = ZERO;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_next = ZERO;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Pulses only on completed windows, so a bounce back into ONE/ZERO stays silent.
  always_comb begin
    w_rise_next = (r_state == WAIT1) && (w_state_next == ONE);
    w_fall_next = (r_state == WAIT0) && (w_state_next == ZERO);
  end

  assign db   = (r_state == ONE) || (r_state == WAIT0);
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: rtl/multi_debounce.sv
// rtl/multi_debounce.sv - shared tick prescaler plus CH debounce channels; MULTI_DEBOUNCE_SYNC_EN adds a 2-flop input synchroniser
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int CH           = 4,
  parameter int TICK_W       = 19,
  parameter int STABLE_TICKS = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  if (STABLE_TICKS < 1) begin : g_bad_stable_ticks
    $error("multi_debounce: STABLE_TICKS must be at least 1");
  end
  if (CH < 1) begin : g_bad_ch
    $error("multi_debounce: CH must be at least 1");
  end

  logic [TICK_W-1:0] r_presc;
  logic              w_tick;
  logic [CH-1:0]     w_sw;

  // Free-running prescaler; the all-zero value marks the tick, so the first tick follows reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + TICK_W'(1);
    end
  end

  assign w_tick = (r_presc == '0);

`ifdef MULTI_DEBOUNCE_SYNC_EN
  logic [CH-1:0] r_sync1;
  logic [CH-1:0] r_sync2;

  // Two-stage synchroniser for switches that are asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sw = r_sync2;
`else
  assign w_sw = sw;
`endif

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .sw_bit(w_sw[gi]),
      .tick  (w_tick),
      .db    (db[gi]),
      .rise  (rise[gi]),
      .fall  (fall[gi])
    );
  end

endmodule

// File: tb/tb_multi_debounce.sv
// tb/tb_multi_debounce.sv - directed self-checking bench for multi_debounce (TICK_W=4, STABLE_TICKS=3)
module tb_multi_debounce;

  localparam int CH     = 4;
  localparam int TICK_W = 4;
  localparam int ST     = 3;
  localparam int PERIOD = 16;
`ifdef MULTI_DEBOUNCE_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  // Stimulus starts S cycles early so the FSMs see the same tick phase in both builds.
  localparam int P0 = (PERIOD + 1 - S) % PERIOD;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] sw    = '0;
  logic [CH-1:0] db;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  multi_debounce #(
    .CH(CH),
    .TICK_W(TICK_W),
    .STABLE_TICKS(ST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw),
    .db   (db),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_phase(input int p);
    do step(1); while ((cyc % PERIOD) != p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int first;
    int n_r;
    int n_f;
    int n_bad;
    int firsts [CH];
    int counts [CH];

    // Reset state
    step(3);
    check_eq("rst_db", db, 0);
    check_eq("rst_rise", rise, 0);
    check_eq("rst_fall", fall, 0);
    check_eq("rst_presc", dut.r_presc, 0);
    reset = 1'b0;
    cyc   = 0;

    // Clean press on channel 0
    wait_phase(P0);
    sw[0] = 1'b1;
    step(47 + S);
    check_eq("press_db_early", db[0], 0);
    check_eq("press_rise_early", rise[0], 0);
    step(1);
    check_eq("press_db", db, 4'b0001);
    check_eq("press_rise", rise, 4'b0001);
    step(1);
    check_eq("press_rise_end", rise, 0);
    check_eq("press_db_hold", db[0], 1);

    // Bouncing press on channel 1
    wait_phase(P0);
    first = -1; n_r = 0; n_f = 0;
    for (int t = 0; t < 130; t++) begin
      sw[1] = (t >= 60) ? 1'b1 : (((t / 5) % 2) == 0);
      step(1);
      if (rise[1]) begin
        n_r++;
        if (first < 0) first = t + 1;
      end
      if (fall[1]) n_f++;
    end
    check_eq("bounce_rise_cnt", n_r, 1);
    check_eq("bounce_rise_cyc", first, 96 + S);
    check_eq("bounce_fall_cnt", n_f, 0);
    check_eq("bounce_db", db, 4'b0011);

    // Release with a one-cycle glitch on channel 0
    wait_phase(P0);
    first = -1; n_r = 0; n_f = 0; n_bad = 0;
    for (int t = 0; t < 90; t++) begin
      sw[0] = (t == 20);
      step(1);
      if ((t + 1 < 64 + S) && !db[0]) n_bad++;
      if (fall[0]) begin
        n_f++;
        if (first < 0) first = t + 1;
      end
      if (rise[0]) n_r++;
    end
    check_eq("release_db_held", n_bad, 0);
    check_eq("release_fall_cnt", n_f, 1);
    check_eq("release_fall_cyc", first, 64 + S);
    check_eq("release_rise_cnt", n_r, 0);
    check_eq("release_db", db, 4'b0010);

    // Bounce coinciding with the final tick of a WAIT1 window on channel 2
    wait_phase(P0);
    n_r = 0; n_bad = 0;
    for (int t = 0; t < 80; t++) begin
      sw[2] = (t < 47);
      step(1);
      if (rise[2]) n_r++;
      if (db[2]) n_bad++;
    end
    check_eq("simul_rise_cnt", n_r, 0);
    check_eq("simul_db_high", n_bad, 0);

    // Asynchronous reset while channel 3 is pulsing rise and channel 1 is in ONE
    wait_phase(P0);
    sw[3] = 1'b1;
    step(48 + S);
    check_eq("pre_reset_db", db, 4'b1010);
    check_eq("pre_reset_rise", rise, 4'b1000);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_db", db, 0);
    check_eq("async_rst_rise", rise, 0);
    check_eq("async_rst_fall", fall, 0);
    sw = '0;
    step(2);
    reset = 1'b0;
    cyc   = 0;
    check_eq("release_presc0", dut.r_presc, 0);
    step(1);
    check_eq("release_presc1", dut.r_presc, 1);
    check_eq("post_rst_db", db, 0);

    // All four channels pressed one cycle apart
    wait_phase(P0);
    for (int c = 0; c < CH; c++) begin
      firsts[c] = -1;
      counts[c] = 0;
    end
    for (int t = 0; t < 70; t++) begin
      if (t < CH) sw[t] = 1'b1;
      step(1);
      for (int c = 0; c < CH; c++) begin
        if (rise[c]) begin
          counts[c]++;
          if (firsts[c] < 0) firsts[c] = t + 1;
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      check_eq($sformatf("multi_lat%0d", c), firsts[c] - c, 48 + S - c);
      check_eq($sformatf("multi_cnt%0d", c), counts[c], 1);
    end
    check_eq("multi_db", db, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
